// File: rtl/logic_pod_readback.sv
// Read-side DRAM arbiter for one logic pod: issues burst reads and forwards the
// returned words to the pod readback FIFO, credit-paced so that FIFO cannot overflow.
module logic_pod_readback #(
    parameter int unsigned POD_NUMBER      = 0,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic         clk_ram_2x,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [2:0]   req_channel,
    input  logic [21:0]  req_ptr,
    input  logic [22:0]  req_count,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    output logic         error,
    output logic         addr_fifo_wr_en,
    output logic [28:0]  addr_fifo_wr_data,
    input  logic [7:0]   addr_fifo_wr_size,
    input  logic         ret_valid,
    input  logic [127:0] ret_data,
    output logic         out_fifo_wr_en,
    output logic [127:0] out_fifo_wr_data,
    output logic         out_fifo_wr_last,
    input  logic [9:0]   out_fifo_wr_size
);

    localparam logic       POD_BIT   = 1'(POD_NUMBER % 2);
    localparam logic [7:0] MAX_BURST = 8'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [2:0]    channel_q;
    logic [21:0]   ptr_q;
    logic [22:0]   remaining_q, remaining_d;
    logic [7:0]    words_q, words_d;
    logic [7:0]    bursts;
    logic          stage_q;
    logic          aborted_q, aborted_d;
    logic          error_q, error_d;
    logic          addr_en_q;
    logic [28:0]   addr_data_q;
    logic          out_en_q;
    logic [127:0]  out_data_q;
    logic          accept_start;
    logic          issue;
    logic          ret_accept;
    logic          discard;
    logic          active;

    always_comb begin
        accept_start = (state_q == StIdle) && start;
        active       = (state_q == StIssue) || (state_q == StDrain);
        bursts       = (words_q + 8'd3) >> 2;
        issue        = (state_q == StIssue) && (remaining_q != 23'd0) && !abort
                       && (addr_fifo_wr_size > 8'd1)
                       && (bursts < MAX_BURST)
                       && ({1'b0, out_fifo_wr_size} > ({3'b000, words_q} + 11'd4));
        // A word sitting in the output stage is already counted; only the rest can be matched.
        ret_accept   = ret_valid && (words_q > {7'd0, stage_q});
        discard      = aborted_q || (active && abort);
        words_d      = words_q + (issue ? 8'd4 : 8'd0) - (stage_q ? 8'd1 : 8'd0);
        remaining_d  = remaining_q - {22'd0, issue};
        error_d      = accept_start ? 1'b0 : (error_q || (ret_valid && !ret_accept));

        aborted_d = aborted_q;
        if (accept_start) begin
            aborted_d = 1'b0;
        end else if (active && abort) begin
            aborted_d = 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (req_count == 23'd0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (abort || (remaining_d == 23'd0)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (words_d == 8'd0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            channel_q   <= 3'd0;
            ptr_q       <= 22'd0;
            remaining_q <= 23'd0;
            words_q     <= 8'd0;
            stage_q     <= 1'b0;
            aborted_q   <= 1'b0;
            error_q     <= 1'b0;
            addr_en_q   <= 1'b0;
            addr_data_q <= 29'd0;
            out_en_q    <= 1'b0;
            out_data_q  <= 128'd0;
        end else begin
            state_q   <= state_d;
            words_q   <= words_d;
            stage_q   <= ret_accept;
            aborted_q <= aborted_d;
            error_q   <= error_d;
            addr_en_q <= issue;
            out_en_q  <= ret_accept && !discard;
            if (ret_valid) begin
                out_data_q <= ret_data;
            end
            if (issue) begin
                addr_data_q <= {1'b0, POD_BIT, channel_q, ptr_q, 2'b00};
            end
            if (accept_start) begin
                channel_q   <= req_channel;
                ptr_q       <= req_ptr;
                remaining_q <= req_count;
            end else begin
                if (issue) begin
                    ptr_q <= ptr_q + 22'd1;
                end
                remaining_q <= remaining_d;
            end
        end
    end

    always_comb begin
        busy              = (state_q != StIdle);
        done              = (state_q == StDone);
        aborted           = done && aborted_q;
        error             = error_q;
        addr_fifo_wr_en   = addr_en_q;
        addr_fifo_wr_data = addr_data_q;
        out_fifo_wr_en    = out_en_q;
        out_fifo_wr_data  = out_data_q;
        out_fifo_wr_last  = out_en_q && (remaining_q == 23'd0) && (words_q == 8'd1);
    end

endmodule
